// File: rtl/niosii_system_ir_transmitter.sv
// niosii_system_ir_transmitter: Avalon-MM slave sending one 32-bit NEC-style IR frame per request.
// Ports: clk, reset_n (async, active-low); address/chipselect/write_n/writedata/readdata form the
// register window (0 tx_data, 1 start/busy, 2 irq_mask, 3 done); irq = done & mask; ir_out = LED drive.
module niosii_system_ir_transmitter #(
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_HALF = 658
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        ir_out
);
  typedef enum logic [2:0] {IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK} state_t;
  state_t      state, state_nx;
  logic [31:0] tx_data, shift, shift_nx, rd;
  logic [19:0] cyc, cyc_nx;
  logic [15:0] ccnt, ccnt_nx;
  logic [4:0]  units, units_nx, len;
  logic [5:0]  bits, bits_nx;
  logic        irq_mask, done_capture, carrier, carrier_nx;
  logic        wr, start, unit_end, state_end, done_set, mark, mark_nx;
  always_comb begin
    wr        = chipselect & ~write_n;
    start     = wr && address == 2'd1 && writedata[0] && state == IDLE;
    len       = state == LEAD_MARK ? 5'd16 : state == LEAD_SPACE ? 5'd8 :
                (state == BIT_SPACE && shift[0]) ? 5'd3 : 5'd1;
    unit_end  = state != IDLE && cyc == 20'(UNIT_CYCLES - 1);
    state_end = unit_end && units == len - 5'd1;
    done_set  = state == STOP_MARK && state_end;
    state_nx  = state;
    shift_nx  = shift;
    bits_nx   = bits;
    cyc_nx    = (state == IDLE || unit_end) ? 20'd0 : cyc + 20'd1;
    units_nx  = unit_end ? units + 5'd1 : units;
    if (start) begin
      state_nx = LEAD_MARK;
      shift_nx = tx_data;
      bits_nx  = 6'd0;
      units_nx = 5'd0;
      cyc_nx   = 20'd0;
    end else if (state_end) begin
      units_nx = 5'd0;
      case (state)
        LEAD_MARK:  state_nx = LEAD_SPACE;
        LEAD_SPACE: state_nx = BIT_MARK;
        BIT_MARK:   state_nx = BIT_SPACE;
        BIT_SPACE: begin
          shift_nx = shift >> 1;
          bits_nx  = bits + 6'd1;
          state_nx = bits == 6'd31 ? STOP_MARK : BIT_MARK;
        end
        default:    state_nx = IDLE;
      endcase
    end
    mark    = state inside {LEAD_MARK, BIT_MARK, STOP_MARK};
    mark_nx = state_nx inside {LEAD_MARK, BIT_MARK, STOP_MARK};
    // every mark begins in a fresh state, so a state change into a mark restarts the carrier phase
    carrier_nx = carrier;
    ccnt_nx    = ccnt;
    if (mark_nx && state_nx != state) begin
      carrier_nx = 1'b1;
      ccnt_nx    = 16'd0;
    end else if (mark) begin
      carrier_nx = ccnt == 16'(CARRIER_HALF - 1) ? ~carrier : carrier;
      ccnt_nx    = ccnt == 16'(CARRIER_HALF - 1) ? 16'd0 : ccnt + 16'd1;
    end
    rd = address == 2'd0 ? tx_data :
         address == 2'd1 ? {31'd0, state != IDLE} :
         address == 2'd2 ? {31'd0, irq_mask} : {31'd0, done_capture};
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state        <= IDLE;
      tx_data      <= 32'd0;
      shift        <= 32'd0;
      cyc          <= 20'd0;
      ccnt         <= 16'd0;
      units        <= 5'd0;
      bits         <= 6'd0;
      irq_mask     <= 1'b0;
      done_capture <= 1'b0;
      carrier      <= 1'b0;
      readdata     <= 32'd0;
      ir_out       <= 1'b0;
    end else begin
      state        <= state_nx;
      shift        <= shift_nx;
      cyc          <= cyc_nx;
      ccnt         <= ccnt_nx;
      units        <= units_nx;
      bits         <= bits_nx;
      carrier      <= carrier_nx;
      readdata     <= rd;
      ir_out       <= mark_nx & carrier_nx;
      if (wr && address == 2'd0) tx_data <= writedata;
      if (wr && address == 2'd2) irq_mask <= writedata[0];
      // completion beats a simultaneous clear
      done_capture <= done_set ? 1'b1 : (wr && address == 2'd3 && writedata[0]) ? 1'b0 : done_capture;
    end
  assign irq = done_capture & irq_mask;
endmodule

// File: tb/tb_niosii_system_ir_transmitter.sv
// tb_niosii_system_ir_transmitter: directed bench for the IR transmitter with UNIT_CYCLES=8, CARRIER_HALF=2.
module tb_niosii_system_ir_transmitter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        irq, ir_out;
  int checks = 0;
  int failures = 0;
  int mism, span, rises, rise_idx, busy_last;
  logic [31:0] r;

  niosii_system_ir_transmitter #(.UNIT_CYCLES(8), .CARRIER_HALF(2)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq), .ir_out(ir_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  function automatic logic car(input int t);
    return ((t / 2) % 2) == 0;
  endfunction

  // expected ir_out for the i-th cycle after the start edge
  function automatic logic exp_ir(input logic [31:0] d, input int i);
    int t, sp;
    t = i;
    if (t < 128) return car(t);
    t -= 128;
    if (t < 64) return 1'b0;
    t -= 64;
    for (int b = 0; b < 32; b++) begin
      if (t < 8) return car(t);
      t -= 8;
      sp = d[b] ? 24 : 8;
      if (t < sp) return 1'b0;
      t -= sp;
    end
    if (t < 8) return car(t);
    return 1'b0;
  endfunction

  // entered at the first sample after the start edge, with address=1 on that edge
  task automatic capture(input logic [31:0] d, input int act, input logic [1:0] act_a,
                         input logic [31:0] act_d, output int mm, output int sp,
                         output int nr, output int ri, output int bl);
    logic [1:0] edge_a;
    logic       prev_irq;
    int         first;
    mm = 0; nr = 0; ri = -1; bl = -1; first = -1;
    edge_a = 2'd1;
    prev_irq = irq;
    for (int i = 0; i < 800; i++) begin
      if (ir_out !== exp_ir(d, i)) mm++;
      if (edge_a == 2'd1 && readdata[0] === 1'b1) begin
        if (first < 0) first = i;
        bl = i;
      end
      if (irq === 1'b1 && prev_irq !== 1'b1) begin
        nr++;
        ri = i;
      end
      prev_irq = irq;
      if (i == act) begin
        chipselect = 1'b1; write_n = 1'b0; address = act_a; writedata = act_d;
      end else if (i == act + 1) begin
        chipselect = 1'b0; write_n = 1'b1; address = 2'd1;
      end
      edge_a = address;
      @(negedge clk);
    end
    sp = (first < 0) ? 0 : bl - first + 1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_ir_out", {31'd0, ir_out}, 32'd0);

    wr(2'd0, 32'hA5A5_0F0F);
    wr(2'd2, 32'd1);
    wr(2'd1, 32'd1);
    chk("start_ir_high", {31'd0, ir_out}, 32'd1);
    #2 reset_n = 1'b0;
    #1 chk("async_rst_ir_out", {31'd0, ir_out}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    chk("after_rst_irq", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), r);
      chk($sformatf("after_rst_reg%0d", a), r, 32'd0);
    end

    wr(2'd1, 32'd1);
    capture(32'd0, -5, 2'd1, 32'd0, mism, span, rises, rise_idx, busy_last);
    chk("t2_wave_mismatches", mism, 32'd0);
    chk("t2_busy_cycles", span, 32'd712);
    chk("t2_irq_masked", rises, 32'd0);
    rd(2'd3, r);
    chk("t2_done", r, 32'd1);
    wr(2'd3, 32'd1);
    rd(2'd3, r);
    chk("t2_done_cleared", r, 32'd0);

    wr(2'd0, 32'd1);
    wr(2'd1, 32'd1);
    capture(32'd1, 300, 2'd0, 32'hFFFF_FFFF, mism, span, rises, rise_idx, busy_last);
    chk("t3_wave_mismatches", mism, 32'd0);
    chk("t3_busy_cycles", span, 32'd728);
    rd(2'd0, r);
    chk("t3_tx_data", r, 32'hFFFF_FFFF);
    wr(2'd3, 32'd1);

    wr(2'd2, 32'd1);
    wr(2'd0, 32'd0);
    wr(2'd1, 32'd1);
    capture(32'd0, 130, 2'd1, 32'd1, mism, span, rises, rise_idx, busy_last);
    chk("t4_wave_mismatches", mism, 32'd0);
    chk("t4_busy_cycles", span, 32'd712);
    chk("t4_done_events", rises, 32'd1);
    chk("t5_irq_after_busy_drop", rise_idx, busy_last);
    chk("t5_irq_set", {31'd0, irq}, 32'd1);
    wr(2'd3, 32'd1);
    chk("t5_irq_cleared", {31'd0, irq}, 32'd0);

    wr(2'd2, 32'd0);
    wr(2'd1, 32'd1);
    capture(32'd0, -5, 2'd1, 32'd0, mism, span, rises, rise_idx, busy_last);
    chk("t5_nomask_irq_events", rises, 32'd0);
    chk("t5_nomask_irq", {31'd0, irq}, 32'd0);
    rd(2'd3, r);
    chk("t5_nomask_done", r, 32'd1);

    wr(2'd3, 32'd1);
    rd(2'd3, r);
    chk("t6_precleared", r, 32'd0);
    wr(2'd1, 32'd1);
    capture(32'd0, 711, 2'd3, 32'd1, mism, span, rises, rise_idx, busy_last);
    chk("t6_wave_mismatches", mism, 32'd0);
    rd(2'd3, r);
    chk("t6_set_beats_clear", r, 32'd1);
    rd(2'd1, r);
    chk("t6_idle", r, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/niosii_system_ir_transmitter.md
Name: niosII_system_ir_transmitter

Overview:
- Avalon-MM slave peripheral that transmits one 32-bit infrared frame per software request on a carrier-modulated LED output (NEC-style pulse-distance coding).
- Transmit counterpart of the IR pushbutton/receiver PIO; same register-window style, a done-capture flag and a maskable IRQ.
- Sits on the Nios II system bus; `ir_out` drives the IR LED driver pin.

Parameters:
UNIT_CYCLES, 28125, clk cycles per timing unit (562.5 us at 50 MHz); legal range 2..2^20
CARRIER_HALF, 658, clk cycles per carrier half-period (~38 kHz at 50 MHz); legal range 1..2^16

Ports:
clk  input  1  system clock; all logic on posedge
reset_n  input  1  asynchronous, active-low reset
address  input  2  register select
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
writedata  input  32  write data
readdata  output  32  registered read data
irq  output  1  interrupt, = done_capture & irq_mask
ir_out  output  1  modulated IR LED drive, registered

Behaviour:
- Reset, asynchronous:
  - readdata=0, ir_out=0, irq=0.
  - tx_data=0, irq_mask=0, done_capture=0.
  - State=IDLE, all counters 0.
- Register map. A write is `chipselect & ~write_n`.
  - addr 0:
    - write: tx_data <= writedata. Allowed at any time; never affects a frame in progress.
    - read: tx_data.
  - addr 1:
    - write: writedata[0]=1 requests start; the request is ignored unless state=IDLE.
    - read: bit0 = busy (state != IDLE), other bits 0.
  - addr 2: irq_mask (bit0), read/write.
  - addr 3:
    - read: bit0 = done_capture.
    - write: writedata[0]=1 clears done_capture.
  - All reads: readdata registered every clock, regardless of chipselect. It reflects the addressed register one cycle after address is presented. Unused bits read 0.
- Start:
  - On the edge sampling a start request in IDLE: shift register <= tx_data, state <= LEAD_MARK, unit counters reset.
  - busy and ir_out=1 are visible in the following cycle.
- FSM states and durations (1 unit = UNIT_CYCLES clocks):
  - IDLE: ir_out=0.
  - LEAD_MARK: 16 units, mark.
  - LEAD_SPACE: 8 units, space.
  - BIT_MARK: 1 unit, mark.
  - BIT_SPACE: 1 unit if the current bit is 0, 3 units if it is 1. Bits are sent LSB first; shift right after each BIT_SPACE. After 32 bits go to STOP_MARK, otherwise return to BIT_MARK.
  - STOP_MARK: 1 unit, mark, then IDLE.
- Frame length:
  - 89 units for tx_data=0.
  - 153 units for tx_data=0xFFFFFFFF.
  - Generally 89 + 2*popcount units.
- Carrier:
  - On every mark entry: carrier <= 1, carrier counter <= 0.
  - During a mark, carrier toggles every CARRIER_HALF clocks.
  - ir_out = carrier during marks, 0 during spaces and IDLE.
  - The carrier is not phase-continuous across marks.
- Completion:
  - On the edge leaving STOP_MARK: state <= IDLE, busy drops, done_capture <= 1.
  - If a clear write to addr 3 occurs on the same edge, set wins and done_capture stays 1.
  - A start request on that same edge is ignored (state was not IDLE when sampled).
- Reset mid-frame: everything returns to reset values immediately; ir_out=0 asynchronously; no done is set.

Test Plan:
1. Reset values.
   - Stimulus: assert reset_n=0 mid-frame.
   - Required: ir_out=0 immediately; busy=0, done=0, irq=0 after release.
   - Then read addr 0..3 -> all 0.
2. Frame timing, tx_data=0, with UNIT_CYCLES=8, CARRIER_HALF=2.
   - Stimulus: write addr1=1.
   - Required: ir_out 1,1,0,0 repeating for 128 cycles, then 0 for 64 cycles.
   - Then 32× (8 cycles carrier, 8 cycles 0), then 8 cycles carrier.
   - busy=1 for exactly 712 cycles.
3. Bit coding, tx_data=0x00000001.
   - Required: first bit space = 24 cycles, remaining bit spaces 8 cycles.
   - Total busy = 728 cycles.
   - Writing tx_data=0xFFFFFFFF mid-frame does not change the waveform.
4. Start while busy.
   - Stimulus: write addr1=1 during LEAD_SPACE.
   - Required: no restart; frame length unchanged; exactly one done event.
5. IRQ and clear.
   - Stimulus: irq_mask=1, run a frame.
   - Required: irq=1 the cycle after busy drops.
   - Write addr3=1 -> irq=0. With irq_mask=0, done=1 but irq stays 0.
6. Set-vs-clear collision.
   - Stimulus: write addr3=1 on the final STOP_MARK edge.
   - Required: done_capture remains 1; addr3 reads 1.
